// File: rtl/rx_frame_radar.sv
// rx_frame_radar: 7E1 UART receiver plus "AAA,DDD#" frame parser.
// Build option: define RX_PARITY_CHECK_EN to reject characters with bad even parity.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   entrada_serial   serial line, idle high, already synchronised
//   angulo[11:0]     last valid angle, one BCD-like nibble per digit
//   medida[11:0]     last valid distance, one nibble per character
//   pronto           one-cycle pulse when a valid frame is latched
//   erro             one-cycle pulse when a character/frame is rejected
//   db_dado[6:0]     last received character
//   db_estado[3:0]   receiver state code
module rx_frame_radar #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [6:0]  db_dado,
    output logic [3:0]  db_estado
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0] HASH  = 7'h23;
    localparam logic [6:0] COMMA = 7'h2C;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    nbit;
    logic [6:0]    shreg;
    logic          seen_high;
    logic [6:0]    rx_char;
    logic          rx_par_ok;
    logic          rx_stop_ok;
`ifdef RX_PARITY_CHECK_EN
    logic          par_bit;
`endif

    // Character receiver. seen_high blocks a line stuck low after a
    // framing error from re-triggering a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            nbit       <= '0;
            shreg      <= '0;
            seen_high  <= 1'b0;
            rx_char    <= '0;
            rx_par_ok  <= 1'b0;
            rx_stop_ok <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    nbit <= '0;
                    if (entrada_serial)
                        seen_high <= 1'b1;
                    else if (seen_high)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        // High at mid start bit: glitch, not a character.
                        state <= entrada_serial ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {entrada_serial, shreg[6:1]};
                        if (nbit == 3'd6)
                            state <= PARITY;
                        else
                            nbit <= nbit + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= STOP;
`ifdef RX_PARITY_CHECK_EN
                        par_bit <= entrada_serial;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        rx_char    <= shreg;
                        rx_stop_ok <= entrada_serial;
                        seen_high  <= entrada_serial;
`ifdef RX_PARITY_CHECK_EN
                        rx_par_ok  <= ~(^{shreg, par_bit});
`else
                        rx_par_ok  <= 1'b1;
`endif
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [2:0]  idx;
    logic        resync;
    logic [11:0] ang_buf;
    logic [11:0] med_buf;
    logic        char_match;

    always_comb begin
        char_match = 1'b0;
        case (idx)
            3'd0, 3'd1, 3'd2:
                char_match = (rx_char >= 7'h30) && (rx_char <= 7'h39);
            3'd3:
                char_match = (rx_char == COMMA);
            3'd4, 3'd5, 3'd6:
                char_match = (rx_char[6:4] == 3'b011);
            default:
                char_match = (rx_char == HASH);
        endcase
    end

    // Frame parser. Digits are shifted into per-field buffers; a frame
    // that restarts at idx 0 always refills all three nibbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx     <= '0;
            resync  <= 1'b1;
            ang_buf <= '0;
            med_buf <= '0;
            angulo  <= '0;
            medida  <= '0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            if (state == DONE) begin
                if (!(rx_par_ok && rx_stop_ok)) begin
                    if (!resync)
                        erro <= 1'b1;
                    resync <= 1'b1;
                    idx    <= '0;
                end else if (resync) begin
                    if (rx_char == HASH) begin
                        resync <= 1'b0;
                        idx    <= '0;
                    end
                end else if (rx_char == HASH) begin
                    // '#' always realigns; only at idx 7 is it a frame.
                    if (idx == 3'd7) begin
                        angulo <= ang_buf;
                        medida <= med_buf;
                        pronto <= 1'b1;
                    end else begin
                        erro <= 1'b1;
                    end
                    idx <= '0;
                end else if (char_match) begin
                    if (idx < 3'd3)
                        ang_buf <= {ang_buf[7:0], rx_char[3:0]};
                    else if (idx > 3'd3)
                        med_buf <= {med_buf[7:0], rx_char[3:0]};
                    idx <= idx + 1'b1;
                end else begin
                    erro   <= 1'b1;
                    resync <= 1'b1;
                    idx    <= '0;
                end
            end
        end
    end

    assign db_dado   = rx_char;
    assign db_estado = {1'b0, state};

endmodule
